// File: rtl/rv_decode_stage.sv
// RV32I(+M) decode stage: combinational decoder feeding a 2-entry (output + skid)
// valid/ready buffer that accepts one instruction per cycle and never stalls fetch combinationally.
package rv_decode_pkg;
  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } instr_code_t;
endpackage

module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ASIZE    = 5,
  parameter int ISIZE    = 32,
  parameter int ENABLE_M = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ISIZE-1:0] in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [5:0]       instr_code,
  output logic [ASIZE-1:0] rs1,
  output logic [ASIZE-1:0] rs2,
  output logic [ASIZE-1:0] rd,
  output logic             use_rs1,
  output logic             use_rs2,
  output logic             we_rd,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [5:0]       code;
    logic [ASIZE-1:0] rs1;
    logic [ASIZE-1:0] rs2;
    logic [ASIZE-1:0] rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             we_rd;
    logic             illegal;
    logic [XLEN-1:0]  imm;
  } entry_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = in_instr[31:0];
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  instr_code_t code;
  logic        u1, u2, wr;
  logic [31:0] imm32;

  // Any encoding that never assigns a code stays OP_NOP, which is what marks it illegal.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    code  = OP_NOP;
    u1    = 1'b0;
    u2    = 1'b0;
    wr    = 1'b0;
    imm32 = '0;
    case (opcode)
      7'b0110011: begin
        u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: code = OP_ADD;  3'd1: code = OP_SLL;
            3'd2: code = OP_SLT;  3'd3: code = OP_SLTU;
            3'd4: code = OP_XOR;  3'd5: code = OP_SRL;
            3'd6: code = OP_OR;   default: code = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
          code = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
          code = OP_SRA;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          case (f3)
            3'd0: code = OP_MUL;  3'd1: code = OP_MULH;
            3'd2: code = OP_MULHSU; 3'd3: code = OP_MULHU;
            3'd4: code = OP_DIV;  3'd5: code = OP_DIVU;
            3'd6: code = OP_REM;  default: code = OP_REMU;
          endcase
        end
      end
      7'b0010011: begin
        u1 = 1'b1; wr = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: code = OP_ADDI;
          3'd2: code = OP_SLTI;
          3'd3: code = OP_SLTIU;
          3'd4: code = OP_XORI;
          3'd6: code = OP_ORI;
          3'd7: code = OP_ANDI;
          3'd1: if (f7 == 7'b0000000) code = OP_SLLI;
          default: begin
            if (f7 == 7'b0000000)      code = OP_SRLI;
            else if (f7 == 7'b0100000) code = OP_SRAI;
          end
        endcase
      end
      7'b0110111: begin wr = 1'b1; imm32 = imm_u; code = OP_LUI;   end
      7'b0010111: begin wr = 1'b1; imm32 = imm_u; code = OP_AUIPC; end
      7'b1101111: begin wr = 1'b1; imm32 = imm_j; code = OP_JAL;   end
      7'b1100111: begin
        u1 = 1'b1; wr = 1'b1; imm32 = imm_i;
        if (f3 == 3'd0) code = OP_JALR;
      end
      7'b1100011: begin
        u1 = 1'b1; u2 = 1'b1; imm32 = imm_b;
        case (f3)
          3'd0: code = OP_BEQ;  3'd1: code = OP_BNE;
          3'd4: code = OP_BLT;  3'd5: code = OP_BGE;
          3'd6: code = OP_BLTU; 3'd7: code = OP_BGEU;
          default: code = OP_NOP;
        endcase
      end
      7'b0000011: begin
        u1 = 1'b1; wr = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0: code = OP_LB;  3'd1: code = OP_LH;  3'd2: code = OP_LW;
          3'd4: code = OP_LBU; 3'd5: code = OP_LHU;
          default: code = OP_NOP;
        endcase
      end
      7'b0100011: begin
        u1 = 1'b1; u2 = 1'b1; imm32 = imm_s;
        case (f3)
          3'd0: code = OP_SB; 3'd1: code = OP_SH; 3'd2: code = OP_SW;
          default: code = OP_NOP;
        endcase
      end
      default: code = OP_NOP;
    endcase
  end

  entry_t dec;
  logic   ill;

  assign ill = (code == OP_NOP);

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.code    = code;
    dec.illegal = ill;
    dec.use_rs1 = u1 & ~ill;
    dec.use_rs2 = u2 & ~ill;
    dec.rs1     = dec.use_rs1 ? ASIZE'(instr[19:15]) : '0;
    dec.rs2     = dec.use_rs2 ? ASIZE'(instr[24:20]) : '0;
    dec.rd      = (wr & ~ill) ? ASIZE'(instr[11:7]) : '0;
    dec.we_rd   = wr & ~ill & (instr[11:7] != 5'd0);
    dec.imm     = ill ? '0 : XLEN'($signed(imm32));
  end

  logic   o_full, s_full;
  entry_t o_q, s_q;
  logic   accept;

  // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
  assign in_ready = ~s_full;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_full <= 1'b0;
      s_full <= 1'b0;
      // NOTE: payload registers are reset too so the presented fields read NOP/0 out of reset.
      o_q    <= '0;
      s_q    <= '0;
    end else if (flush) begin
      o_full <= 1'b0;
      s_full <= 1'b0;
    end else if (!o_full || out_ready) begin
      // NOTE: non-blocking throughout, so the S->O move reads the pre-edge skid contents.
      if (s_full) begin
        o_q    <= s_q;
        o_full <= 1'b1;
        s_full <= 1'b0;
      end else if (accept) begin
        o_q    <= dec;
        o_full <= 1'b1;
      end else begin
        o_full <= 1'b0;
      end
    end else if (accept) begin
      s_q    <= dec;
      s_full <= 1'b1;
    end
  end

  assign out_valid  = o_full;
  assign out_pc     = o_q.pc;
  assign instr_code = o_q.code;
  assign rs1        = o_q.rs1;
  assign rs2        = o_q.rs2;
  assign rd         = o_q.rd;
  assign use_rs1    = o_q.use_rs1;
  assign use_rs2    = o_q.use_rs2;
  assign we_rd      = o_q.we_rd;
  assign imm        = o_q.imm;
  assign illegal    = o_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vectors, M-extension gating, back-pressure,
// flush and reset behaviour, with hand-computed expectations.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready_m, out_valid_m, use_rs1_m, use_rs2_m, we_rd_m, illegal_m;
  logic [31:0] out_pc_m, imm_m;
  logic [5:0]  code_m;
  logic [4:0]  rs1_m, rs2_m, rd_m;

  logic        in_ready_n, out_valid_n, use_rs1_n, use_rs2_n, we_rd_n, illegal_n;
  logic [31:0] out_pc_n, imm_n;
  logic [5:0]  code_n;
  logic [4:0]  rs1_n, rs2_n, rd_n;

  rv_decode_stage #(.XLEN(32), .ASIZE(5), .ISIZE(32), .ENABLE_M(1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_pc(out_pc_m), .instr_code(code_m), .rs1(rs1_m), .rs2(rs2_m), .rd(rd_m),
    .use_rs1(use_rs1_m), .use_rs2(use_rs2_m), .we_rd(we_rd_m), .imm(imm_m), .illegal(illegal_m)
  );

  rv_decode_stage #(.XLEN(32), .ASIZE(5), .ISIZE(32), .ENABLE_M(0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_pc(out_pc_n), .instr_code(code_n), .rs1(rs1_n), .rs2(rs2_n), .rd(rd_n),
    .use_rs1(use_rs1_n), .use_rs2(use_rs2_n), .we_rd(we_rd_n), .imm(imm_n), .illegal(illegal_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;

  always @(posedge clk)
    if (rst && !flush && in_valid && in_ready_m) acc_cnt <= acc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    in_valid = v;
    in_instr = i;
    in_pc    = p;
  endtask

  task automatic check_dec(input string tag, input logic [5:0] code,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                           input logic u1, input logic u2, input logic we,
                           input logic [31:0] immv, input logic ill);
    check({tag, ".valid"}, out_valid_m, 1'b1);
    check({tag, ".code"},  code_m, code);
    check({tag, ".rs1"},   rs1_m, r1);
    check({tag, ".rs2"},   rs2_m, r2);
    check({tag, ".rd"},    rd_m, rdv);
    check({tag, ".use1"},  use_rs1_m, u1);
    check({tag, ".use2"},  use_rs2_m, u2);
    check({tag, ".we"},    we_rd_m, we);
    check({tag, ".imm"},   imm_m, immv);
    check({tag, ".ill"},   illegal_m, ill);
  endtask

  int a0;

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check("rst.valid", out_valid_m, 1'b0);
    check("rst.code",  code_m, OP_NOP);
    check("rst.imm",   imm_m, 32'h0);
    check("rst.pc",    out_pc_m, 32'h0);
    rst = 1'b1;
    step();
    check("idle.ready", in_ready_m, 1'b1);
    check("idle.valid", out_valid_m, 1'b0);

    // Decode vectors, one per cycle with out_ready high
    drive(1'b1, 32'h002081B3, 32'h0000_1000); step();
    check_dec("add", OP_ADD, 1, 2, 3, 1, 1, 1, 32'h0, 0);
    check("add.pc", out_pc_m, 32'h0000_1000);
    drive(1'b1, 32'hFFF00293, 32'h0000_1004); step();
    check_dec("addi", OP_ADDI, 0, 0, 5, 1, 0, 1, 32'hFFFF_FFFF, 0);
    check("addi.pc", out_pc_m, 32'h0000_1004);
    drive(1'b1, 32'h0020A423, 32'h0000_1008); step();
    check_dec("sw", OP_SW, 1, 2, 0, 1, 1, 0, 32'h0000_0008, 0);
    drive(1'b1, 32'hFE209EE3, 32'h0000_100C); step();
    check_dec("bne", OP_BNE, 1, 2, 0, 1, 1, 0, 32'hFFFF_FFFC, 0);
    drive(1'b1, 32'h001000EF, 32'h0000_1010); step();
    check_dec("jal", OP_JAL, 0, 0, 1, 0, 0, 1, 32'h0000_0800, 0);
    drive(1'b1, 32'h022081B3, 32'h0000_1014); step();
    check_dec("mul", OP_MUL, 1, 2, 3, 1, 1, 1, 32'h0, 0);
    check("mul_off.valid", out_valid_n, 1'b1);
    check("mul_off.ill",   illegal_n, 1'b1);
    check("mul_off.code",  code_n, OP_NOP);
    check("mul_off.we",    we_rd_n, 1'b0);
    check("mul_off.rd",    rd_n, 5'd0);
    check("mul_off.use1",  use_rs1_n, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 32'h0000_1018); step();
    check_dec("ones", OP_NOP, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1'b1, 32'h40109093, 32'h0000_101C); step();
    check_dec("slli_bad", OP_NOP, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1'b1, 32'h4010D093, 32'h0000_1020); step();
    check_dec("srai", OP_SRAI, 1, 0, 1, 1, 0, 1, 32'h0000_0401, 0);
    drive(1'b1, 32'h002081B0, 32'h0000_1024); step();
    check_dec("lowbits", OP_NOP, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1'b1, 32'h12345037, 32'h0000_1028); step();
    check_dec("lui_x0", OP_LUI, 0, 0, 0, 0, 0, 0, 32'h1234_5000, 0);
    drive(1'b0, 32'h0, 32'h0); step();
    check("drain.valid", out_valid_m, 1'b0);

    // Back-pressure: four ADDIs (rd 1..4), out_ready low for three edges
    out_ready = 1'b0;
    a0 = acc_cnt;
    drive(1'b1, 32'h00100093, 32'h100); step();
    check("bp1.valid", out_valid_m, 1'b1);
    check("bp1.pc",    out_pc_m, 32'h100);
    check("bp1.ready", in_ready_m, 1'b1);
    drive(1'b1, 32'h00200113, 32'h104); step();
    check("bp2.ready", in_ready_m, 1'b0);
    check("bp2.pc",    out_pc_m, 32'h100);
    drive(1'b1, 32'h00300193, 32'h108); step();
    check("bp3.ready", in_ready_m, 1'b0);
    check("bp3.pc",    out_pc_m, 32'h100);
    check("bp3.rd",    rd_m, 5'd1);
    check("bp3.accepted", acc_cnt - a0, 2);
    out_ready = 1'b1;
    step();
    check("rel1.pc",    out_pc_m, 32'h104);
    check("rel1.rd",    rd_m, 5'd2);
    check("rel1.ready", in_ready_m, 1'b1);
    step();
    check("rel2.pc", out_pc_m, 32'h108);
    check("rel2.rd", rd_m, 5'd3);
    drive(1'b1, 32'h00400213, 32'h10C); step();
    check("rel3.pc",  out_pc_m, 32'h10C);
    check("rel3.imm", imm_m, 32'h4);
    drive(1'b0, 32'h0, 32'h0); step();
    check("rel4.valid", out_valid_m, 1'b0);
    check("stream.accepted", acc_cnt - a0, 4);

    // Flush with skid full and a pending instruction
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200); step();
    drive(1'b1, 32'h00200113, 32'h204); step();
    check("fl_pre.ready", in_ready_m, 1'b0);
    drive(1'b1, 32'h00300193, 32'h208); flush = 1'b1; step();
    flush = 1'b0;
    check("fl1.valid", out_valid_m, 1'b0);
    check("fl1.ready", in_ready_m, 1'b1);
    drive(1'b0, 32'h0, 32'h0); step();
    check("fl1b.valid", out_valid_m, 1'b0);

    // Flush coinciding with an accept into the skid slot: the entry must be dropped
    drive(1'b1, 32'h00100093, 32'h300); step();
    check("fl2_pre.valid", out_valid_m, 1'b1);
    drive(1'b1, 32'h00200113, 32'h304); flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl2.valid", out_valid_m, 1'b0);
    out_ready = 1'b1; step();
    check("fl2b.valid", out_valid_m, 1'b0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h400); step();
    drive(1'b1, 32'hFFF00293, 32'h404); step();
    check("rs_pre.ready", in_ready_m, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rs.valid", out_valid_m, 1'b0);
    check("rs.ready", in_ready_m, 1'b1);
    check("rs.code",  code_m, OP_NOP);
    check("rs.rd",    rd_m, 5'd0);
    check("rs.rs1",   rs1_m, 5'd0);
    check("rs.imm",   imm_m, 32'h0);
    check("rs.pc",    out_pc_m, 32'h0);
    check("rs.we",    we_rd_m, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    #3 rst = 1'b1;
    step();
    check("post_rs.valid", out_valid_m, 1'b0);
    check("post_rs.ready", in_ready_m, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
